pwm_multi_channel: RTL and testbench
====================================

# pwm_multi_channel

Parametrised successor to the current single-duty PWM peripheral: drives `NUM_CH` outputs, each with its own duty cycle, from one shared period counter with programmable period (TOP) and clock prescaler. Duty, TOP and prescale are double-buffered and take effect only at a period boundary, so outputs never glitch mid-period. It sits between the SPI register file, which supplies enables, TOP, prescale and per-channel duty writes, and the `{uio_out, uo_out}` pin bus.

## Interface
Parameters:
- `NUM_CH`, 16: number of output channels (1..64).
- `CNT_W`, 8: width of the counter, TOP and duty values.
- `PRE_W`, 8: width of the prescaler.

Ports:
- `clk`  in  1: single clock; all state is on its rising edge.
- `rst_n`  in  1: reset, synchronous and active-low.
- `en_out`  in  NUM_CH: per-channel output enable.
- `en_pwm`  in  NUM_CH: per-channel PWM enable. When 0, an enabled output is driven static high.
- `top`  in  CNT_W: requested period minus 1. Sampled only at a boundary.
- `prescale`  in  PRE_W: requested divider minus 1. Sampled only at a boundary.
- `wr_en`  in  1: one-cycle duty write strobe.
- `wr_ch`  in  $clog2(NUM_CH) (min 1): channel to write. Indices ≥ NUM_CH are ignored.
- `wr_duty`  in  CNT_W: duty value for the write.
- `out`  out  NUM_CH: registered PWM outputs.
- `period_start`  out  1: one-cycle pulse in the first cycle of each new period.
- `update_pending`  out  1: high while a duty write has not yet been applied.

## Operation
- State:
  - Staging duty registers `stg[i]`.
  - Active registers `act_duty[i]`, `act_top` and `act_pre`.
  - Prescaler count `pcnt`, period counter `cnt`, and a pending flag.
- Duty write: when `wr_en` is high and `wr_ch` < NUM_CH, set `stg[wr_ch]` ← `wr_duty` and set the pending flag.
- Tick: asserted when `pcnt == act_pre`. On a tick `pcnt` ← 0, otherwise `pcnt` increments.
- Counter: on a tick, `cnt` ← 0 if `cnt == act_top` (wrap), otherwise `cnt` + 1. Between ticks `cnt` holds.
- Boundary (wrap tick), in the same edge:
  - `act_duty[i]` ← `stg[i]` for every channel.
  - `act_top` ← `top`.
  - `act_pre` ← `prescale`.
  - The pending flag is cleared.
  - `period_start` is registered high for the next cycle.
- Output, registered every cycle: `out[i]` ← `en_out[i]` & (~`en_pwm[i]` | (`cnt` < `act_duty[i]`)). The comparison is unsigned at CNT_W bits.
- Duty semantics:
  - duty 0 gives 0 %.
  - duty > `act_top` gives 100 %.
  - Otherwise the output is high for `duty`×(`act_pre`+1) clocks out of (`act_top`+1)×(`act_pre`+1).
- TOP = 0: every tick is a wrap and a boundary. Any duty ≥ 1 gives a constant high output.

## Timing
- Reset values (the cycle after an edge with `rst_n` low):
  - `out` = 0, `period_start` = 0, `update_pending` = 0.
  - `cnt` = 0, `pcnt` = 0.
  - `stg` = 0, `act_duty` = 0, `act_top` = all-ones, `act_pre` = 0.
- Reset mid-period: it aborts the period, and pending writes are lost.
- Output latency: `out` reflects the `cnt`/enable values of the previous cycle. The output is high in the cycle after `cnt` takes a value below duty.
- Enable latency: a change on `en_out`/`en_pwm` appears on `out` 1 cycle later. Enables are not double-buffered.
- Write latency: a write in any cycle of period N is applied from period N+1.
- Write coinciding with the boundary edge:
  - That write lands in `stg` only. The boundary loads the old staging value.
  - The pending flag stays set, and the new value is applied at the following boundary.
- `update_pending` is high from the cycle after the write until the cycle after the boundary that applies it.
- `period_start` is high exactly in the cycle where `cnt` first reads 0 after a wrap. It is not asserted after reset until the first wrap.
- A change to `top`/`prescale` mid-period has no effect until the boundary.

## Test plan
- Setup for all tests: NUM_CH=4, CNT_W=8, PRE_W=8, all `en_out` = 1, all `en_pwm` = 1.
- TOP=9, prescale=0, write ch0 duty=3, then wait two boundaries -> `out[0]` is high 3 of every 10 clocks, and `period_start` fires every 10 clocks.
- TOP=3, prescale=1, ch1 duty=2 -> `out[1]` is high 4 clocks, low 4 clocks, period 8.
- ch2 duty=0 -> constant low. ch2 duty=0xFF with TOP=9 -> constant high. ch3 with `en_pwm`=0 -> constant high. ch3 with `en_out`=0 -> constant low, arriving 1 cycle after the enable change.
- With ch0 duty=3, write ch0 duty=7 mid-period:
  - The current period still shows 3 high clocks, and the next shows 7.
  - `update_pending` is high from the write until the cycle after the boundary.
  - Repeat with the write on the boundary edge: 7 appears one period later.
- Change TOP from 9 to 4 mid-period -> the current period stays 10 clocks, and the next is 5.
- Assert `rst_n`=0 for 1 cycle mid-period -> `out` = 0 next cycle, the pending write is discarded, and `period_start` stays low until the first wrap at TOP=255.

Source files
------------

// File: rtl/pwm_multi_channel.sv
// Multi-channel PWM generator sharing one prescaled period counter.
// Duty, TOP and prescale are staged and only take effect at a period wrap.
module pwm_multi_channel #(
  parameter int unsigned NUM_CH = 16,
  parameter int unsigned CNT_W  = 8,
  parameter int unsigned PRE_W  = 8,
  localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] en_out,
  input  logic [NUM_CH-1:0] en_pwm,
  input  logic [CNT_W-1:0]  top,
  input  logic [PRE_W-1:0]  prescale,
  input  logic              wr_en,
  input  logic [CH_W-1:0]   wr_ch,
  input  logic [CNT_W-1:0]  wr_duty,
  output logic [NUM_CH-1:0] out,
  output logic              period_start,
  output logic              update_pending
);

  logic [CNT_W-1:0] stg      [NUM_CH];
  logic [CNT_W-1:0] act_duty [NUM_CH];
  logic [CNT_W-1:0] act_top;
  logic [PRE_W-1:0] act_pre;
  logic [PRE_W-1:0] pcnt;
  logic [CNT_W-1:0] cnt;

  logic tick;
  logic wrap;
  logic wr_ok;

  assign tick  = (pcnt == act_pre);
  assign wrap  = tick && (cnt == act_top);
  assign wr_ok = wr_en && (32'(wr_ch) < NUM_CH);

  // Prescaler and period counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pcnt <= '0;
      cnt  <= '0;
    end else begin
      if (tick) begin
        pcnt <= '0;
        cnt  <= wrap ? '0 : cnt + CNT_W'(1);
      end else begin
        pcnt <= pcnt + PRE_W'(1);
      end
    end
  end

  // Staging registers; a write on the wrap edge stays staged for the next period
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        stg[i] <= '0;
      end
    end else if (wr_ok) begin
      stg[wr_ch] <= wr_duty;
    end
  end

  // Pending flag: a coincident write wins over the wrap clear
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      update_pending <= 1'b0;
    end else if (wr_ok) begin
      update_pending <= 1'b1;
    end else if (wrap) begin
      update_pending <= 1'b0;
    end
  end

  // Active settings loaded only at the wrap
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        act_duty[i] <= '0;
      end
      act_top      <= '1;
      act_pre      <= '0;
      period_start <= 1'b0;
    end else begin
      period_start <= wrap;
      if (wrap) begin
        for (int unsigned i = 0; i < NUM_CH; i++) begin
          act_duty[i] <= stg[i];
        end
        act_top <= top;
        act_pre <= prescale;
      end
    end
  end

  // Registered outputs; a disabled PWM with an enabled output drives high
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        out[i] <= en_out[i] & (~en_pwm[i] | (cnt < act_duty[i]));
      end
    end
  end

endmodule

// File: tb/tb_pwm_multi_channel.sv
// Directed bench for pwm_multi_channel with four channels; each period is
// measured from one period_start pulse to the next.
module tb_pwm_multi_channel;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] en_out;
  logic [3:0] en_pwm;
  logic [7:0] top;
  logic [7:0] prescale;
  logic       wr_en;
  logic [1:0] wr_ch;
  logic [7:0] wr_duty;
  logic [3:0] out;
  logic       period_start;
  logic       update_pending;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pwm_multi_channel #(
    .NUM_CH(4),
    .CNT_W (8),
    .PRE_W (8)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .en_out        (en_out),
    .en_pwm        (en_pwm),
    .top           (top),
    .prescale      (prescale),
    .wr_en         (wr_en),
    .wr_ch         (wr_ch),
    .wr_duty       (wr_duty),
    .out           (out),
    .period_start  (period_start),
    .update_pending(update_pending)
  );

  // Samples one period (from just after a period_start up to and including the next);
  // optionally issues a duty write in sample slot wr_at.
  task automatic measure(input int ch, input int wr_at, input logic [1:0] wc,
                         input logic [7:0] wd, output int hi, output int len,
                         output int pend);
    hi = 0;
    len = 0;
    pend = 0;
    for (int i = 0; i < 1000; i++) begin
      if (i == wr_at) begin
        wr_ch   = wc;
        wr_duty = wd;
        wr_en   = 1'b1;
      end
      @(negedge clk);
      wr_en = 1'b0;
      len++;
      if (out[ch]) hi++;
      if (update_pending) pend++;
      if (period_start) return;
    end
    len = -1;
  endtask

  task automatic wait_ps(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (period_start) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic do_write(input logic [1:0] ch, input logic [7:0] d);
    wr_ch   = ch;
    wr_duty = d;
    wr_en   = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (out !== 4'h0) begin bad++; $display("FAIL reset_out got=%h want=0", out); end
    total++;
    if (period_start !== 1'b0) begin bad++; $display("FAIL reset_ps got=%b want=0", period_start); end
    total++;
    if (update_pending !== 1'b0) begin bad++; $display("FAIL reset_pend got=%b want=0", update_pending); end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int hi, len, pend;
    bit ok;
    do_write(2'd0, 8'd3);
    wait_ps(600, ok);
    total++;
    if (ok !== 1'b1) begin bad++; $display("FAIL basic_first_wrap got=timeout want=period_start"); end
    for (int k = 0; k < 2; k++) begin
      measure(0, -1, 2'd0, 8'd0, hi, len, pend);
      total++;
      if (len !== 10) begin bad++; $display("FAIL basic_len got=%0d want=10", len); end
      total++;
      if (hi !== 3) begin bad++; $display("FAIL basic_hi got=%0d want=3", hi); end
    end
    measure(1, -1, 2'd0, 8'd0, hi, len, pend);
    total++;
    if (hi !== 0) begin bad++; $display("FAIL duty0_ch1_hi got=%0d want=0", hi); end
  endtask

  task automatic test_duty_edges();
    int hi, len, pend;
    bit ok;
    measure(2, 0, 2'd2, 8'h00, hi, len, pend);
    total++;
    if (hi !== 0) begin bad++; $display("FAIL ch2_duty0_hi got=%0d want=0", hi); end
    measure(2, 0, 2'd2, 8'hFF, hi, len, pend);
    measure(2, -1, 2'd0, 8'd0, hi, len, pend);
    total++;
    if (hi !== 10 || len !== 10) begin bad++; $display("FAIL ch2_dutyff got=%0d/%0d want=10/10", hi, len); end
    // ch3 has duty 0: PWM disable forces it high one cycle after the change
    total++;
    if (out[3] !== 1'b0) begin bad++; $display("FAIL ch3_pre_low got=%b want=0", out[3]); end
    en_pwm[3] = 1'b0;
    @(negedge clk);
    total++;
    if (out[3] !== 1'b1) begin bad++; $display("FAIL ch3_pwm_off got=%b want=1", out[3]); end
    wait_ps(100, ok);
    measure(3, -1, 2'd0, 8'd0, hi, len, pend);
    total++;
    if (hi !== 10) begin bad++; $display("FAIL ch3_static_hi got=%0d want=10", hi); end
    en_out[3] = 1'b0;
    total++;
    if (out[3] !== 1'b1) begin bad++; $display("FAIL ch3_en_same_cycle got=%b want=1", out[3]); end
    @(negedge clk);
    total++;
    if (out[3] !== 1'b0) begin bad++; $display("FAIL ch3_en_off got=%b want=0", out[3]); end
    en_out = 4'hF;
    en_pwm = 4'hF;
    wait_ps(100, ok);
    total++;
    if (ok !== 1'b1) begin bad++; $display("FAIL resync got=timeout want=period_start"); end
  endtask

  task automatic test_midwrite();
    int hi, len, pend;
    measure(0, 4, 2'd0, 8'd7, hi, len, pend);
    total++;
    if (hi !== 3) begin bad++; $display("FAIL mid_cur_hi got=%0d want=3", hi); end
    total++;
    if (pend !== 5) begin bad++; $display("FAIL mid_pend got=%0d want=5", pend); end
    measure(0, -1, 2'd0, 8'd0, hi, len, pend);
    total++;
    if (hi !== 7) begin bad++; $display("FAIL mid_next_hi got=%0d want=7", hi); end
    total++;
    if (pend !== 0) begin bad++; $display("FAIL mid_pend_clr got=%0d want=0", pend); end
  endtask

  task automatic test_back_to_back();
    int hi, len, pend;
    measure(0, 0, 2'd0, 8'd3, hi, len, pend);
    total++;
    if (hi !== 7 || pend !== 9) begin bad++; $display("FAIL b2b_setup got=%0d/%0d want=7/9", hi, pend); end
    // write lands on the wrap edge: staged only, applied one period later
    measure(0, 9, 2'd0, 8'd7, hi, len, pend);
    total++;
    if (hi !== 3 || pend !== 1) begin bad++; $display("FAIL bnd_p0 got=%0d/%0d want=3/1", hi, pend); end
    measure(0, -1, 2'd0, 8'd0, hi, len, pend);
    total++;
    if (hi !== 3 || pend !== 9) begin bad++; $display("FAIL bnd_p1 got=%0d/%0d want=3/9", hi, pend); end
    measure(0, -1, 2'd0, 8'd0, hi, len, pend);
    total++;
    if (hi !== 7 || pend !== 0) begin bad++; $display("FAIL bnd_p2 got=%0d/%0d want=7/0", hi, pend); end
  endtask

  task automatic test_top_change();
    int hi, len, pend;
    top = 8'd4;
    measure(0, -1, 2'd0, 8'd0, hi, len, pend);
    total++;
    if (len !== 10) begin bad++; $display("FAIL top_cur_len got=%0d want=10", len); end
    measure(0, -1, 2'd0, 8'd0, hi, len, pend);
    total++;
    if (len !== 5) begin bad++; $display("FAIL top_next_len got=%0d want=5", len); end
    total++;
    if (hi !== 5) begin bad++; $display("FAIL duty_over_top_hi got=%0d want=5", hi); end
  endtask

  task automatic test_prescale();
    int hi, len, pend;
    top      = 8'd3;
    prescale = 8'd1;
    measure(1, 0, 2'd1, 8'd2, hi, len, pend);
    total++;
    if (len !== 5) begin bad++; $display("FAIL pre_cur_len got=%0d want=5", len); end
    for (int k = 0; k < 2; k++) begin
      measure(1, -1, 2'd0, 8'd0, hi, len, pend);
      total++;
      if (len !== 8) begin bad++; $display("FAIL pre_len got=%0d want=8", len); end
      total++;
      if (hi !== 4) begin bad++; $display("FAIL pre_hi got=%0d want=4", hi); end
    end
  endtask

  task automatic test_top_zero();
    int hi, len, pend;
    top      = 8'd0;
    prescale = 8'd0;
    measure(0, -1, 2'd0, 8'd0, hi, len, pend);
    total++;
    if (len !== 8) begin bad++; $display("FAIL top0_cur_len got=%0d want=8", len); end
    for (int k = 0; k < 2; k++) begin
      measure(0, -1, 2'd0, 8'd0, hi, len, pend);
      total++;
      if (len !== 1 || hi !== 1) begin bad++; $display("FAIL top0 got=%0d/%0d want=1/1", len, hi); end
    end
  endtask

  task automatic test_reset_mid();
    int hi, len, pend;
    top = 8'd9;
    measure(0, -1, 2'd0, 8'd0, hi, len, pend);
    measure(0, -1, 2'd0, 8'd0, hi, len, pend);
    total++;
    if (len !== 10 || hi !== 7) begin bad++; $display("FAIL rst_pre got=%0d/%0d want=10/7", len, hi); end
    repeat (2) @(negedge clk);
    do_write(2'd0, 8'd1);
    total++;
    if (update_pending !== 1'b1) begin bad++; $display("FAIL rst_pend_set got=%b want=1", update_pending); end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    total++;
    if (out !== 4'h0 || period_start !== 1'b0 || update_pending !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid got=%h/%b/%b want=0/0/0", out, period_start, update_pending);
    end
    measure(0, -1, 2'd0, 8'd0, hi, len, pend);
    total++;
    if (len !== 256) begin bad++; $display("FAIL rst_first_wrap got=%0d want=256", len); end
    total++;
    if (hi !== 0) begin bad++; $display("FAIL rst_first_hi got=%0d want=0", hi); end
    measure(0, -1, 2'd0, 8'd0, hi, len, pend);
    total++;
    if (len !== 10 || hi !== 0) begin bad++; $display("FAIL rst_discard got=%0d/%0d want=10/0", len, hi); end
  endtask

  initial begin
    rst_n    = 1'b0;
    en_out   = 4'hF;
    en_pwm   = 4'hF;
    top      = 8'd9;
    prescale = 8'd0;
    wr_en    = 1'b0;
    wr_ch    = 2'd0;
    wr_duty  = 8'd0;
    test_reset();
    test_basic();
    test_duty_edges();
    test_midwrite();
    test_back_to_back();
    test_top_change();
    test_prescale();
    test_top_zero();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
